// File: rtl/dma_adma_engine.sv
// Descriptor-driven DMA engine moving words between RAM and a FIFO.
// Descriptors are fetched over a req/ack handshake; each word takes an A/B cycle pair.
module dma_adma_engine #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 64,
   parameter int LEN_W       = 12,
   parameter int DESC_STRIDE = 8,
   parameter int MAX_DESC    = 16
) (
   input  logic              clk_in,
   input  logic              reset_n,
   input  logic              start,
   input  logic              continue_in,
   input  logic              stop,
   input  logic              write,
   input  logic              error_in,
   input  logic [ADDR_W-1:0] base_ptr,
   output logic              desc_req,
   output logic [ADDR_W-1:0] desc_ptr,
   input  logic              desc_ack,
   input  logic              desc_valid,
   input  logic              desc_end,
   input  logic [1:0]        desc_act,
   input  logic [ADDR_W-1:0] desc_addr,
   input  logic [LEN_W-1:0]  desc_len,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd,
   output logic              ram_wr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              fifo_wr,
   output logic [DATA_W-1:0] fifo_wdata,
   input  logic              fifo_full,
   output logic              fifo_rd,
   input  logic [DATA_W-1:0] fifo_rdata,
   input  logic              fifo_empty,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code
);

   localparam int CNT_W = $clog2(MAX_DESC + 1);
   localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);
   localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(DESC_STRIDE);

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, XFER_A, XFER_B, PAUSE, NEXT, DONE, ERR
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr_q, ptr_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [LEN_W-1:0]  wcnt_q, wcnt_nxt;
   logic [CNT_W-1:0]  dcnt_q, dcnt_nxt;
   logic              dir_q, dir_nxt;
   logic              link_q, link_nxt;
   logic              err_q, err_nxt;
   logic [1:0]        code_q, code_nxt;
   logic              d_valid_q, d_valid_nxt;
   logic              d_end_q, d_end_nxt;
   logic [1:0]        d_act_q, d_act_nxt;
   logic [ADDR_W-1:0] d_addr_q, d_addr_nxt;
   logic [LEN_W-1:0]  d_len_q, d_len_nxt;
   logic              busy_s, desc_req_s, ram_rd_s, ram_wr_s, fifo_rd_s, fifo_wr_s;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         ptr_q     <= '0;
         addr_q    <= '0;
         wcnt_q    <= '0;
         dcnt_q    <= '0;
         dir_q     <= 1'b0;
         link_q    <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= 2'b00;
         d_valid_q <= 1'b0;
         d_end_q   <= 1'b0;
         d_act_q   <= 2'b00;
         d_addr_q  <= '0;
         d_len_q   <= '0;
      end else begin
         state     <= state_nxt;
         ptr_q     <= ptr_nxt;
         addr_q    <= addr_nxt;
         wcnt_q    <= wcnt_nxt;
         dcnt_q    <= dcnt_nxt;
         dir_q     <= dir_nxt;
         link_q    <= link_nxt;
         err_q     <= err_nxt;
         code_q    <= code_nxt;
         d_valid_q <= d_valid_nxt;
         d_end_q   <= d_end_nxt;
         d_act_q   <= d_act_nxt;
         d_addr_q  <= d_addr_nxt;
         d_len_q   <= d_len_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr_q;
      addr_nxt    = addr_q;
      wcnt_nxt    = wcnt_q;
      dcnt_nxt    = dcnt_q;
      dir_nxt     = dir_q;
      link_nxt    = link_q;
      err_nxt     = err_q;
      code_nxt    = code_q;
      d_valid_nxt = d_valid_q;
      d_end_nxt   = d_end_q;
      d_act_nxt   = d_act_q;
      d_addr_nxt  = d_addr_q;
      d_len_nxt   = d_len_q;
      desc_req_s  = 1'b0;
      ram_rd_s    = 1'b0;
      ram_wr_s    = 1'b0;
      fifo_rd_s   = 1'b0;
      fifo_wr_s   = 1'b0;
      busy_s      = !(state == IDLE || state == DONE || state == ERR);

      // External abort outranks everything and leaves every strobe low this cycle
      if (busy_s && error_in) begin
         state_nxt = ERR;
         err_nxt   = 1'b1;
         code_nxt  = 2'b10;
      end else begin
         case (state)
            IDLE, ERR: begin
               if (start) begin
                  ptr_nxt   = base_ptr;
                  dir_nxt   = write;
                  dcnt_nxt  = '0;
                  err_nxt   = 1'b0;
                  code_nxt  = 2'b00;
                  state_nxt = FETCH;
               end
            end
            FETCH: begin
               desc_req_s = 1'b1;
               if (desc_ack) begin
                  d_valid_nxt = desc_valid;
                  d_end_nxt   = desc_end;
                  d_act_nxt   = desc_act;
                  d_addr_nxt  = desc_addr;
                  d_len_nxt   = desc_len;
                  dcnt_nxt    = dcnt_q + CNT_W'(1);
                  state_nxt   = DECODE;
               end
            end
            DECODE: begin
               link_nxt = 1'b0;
               if (!d_valid_q || d_act_q == 2'b01) begin
                  state_nxt = ERR;
                  err_nxt   = 1'b1;
                  code_nxt  = 2'b01;
               end else if (d_act_q == 2'b11) begin
                  ptr_nxt   = d_addr_q;
                  link_nxt  = 1'b1;
                  state_nxt = NEXT;
               end else if (d_act_q == 2'b10 && d_len_q != '0) begin
                  addr_nxt  = d_addr_q;
                  wcnt_nxt  = d_len_q;
                  state_nxt = XFER_A;
               end else begin
                  state_nxt = NEXT;
               end
            end
            XFER_A: begin
               if (stop) begin
                  state_nxt = PAUSE;
               end else if (dir_q) begin
                  if (!fifo_full) begin
                     ram_rd_s  = 1'b1;
                     state_nxt = XFER_B;
                  end
               end else if (!fifo_empty) begin
                  fifo_rd_s = 1'b1;
                  state_nxt = XFER_B;
               end
            end
            XFER_B: begin
               fifo_wr_s = dir_q;
               ram_wr_s  = !dir_q;
               addr_nxt  = addr_q + WORD_BYTES;
               wcnt_nxt  = wcnt_q - LEN_W'(1);
               state_nxt = (wcnt_q == LEN_W'(1)) ? NEXT : XFER_A;
            end
            PAUSE: begin
               if (!stop && continue_in) state_nxt = XFER_A;
            end
            NEXT: begin
               if (d_end_q) begin
                  state_nxt = DONE;
               end else if (dcnt_q == CNT_W'(MAX_DESC)) begin
                  state_nxt = ERR;
                  err_nxt   = 1'b1;
                  code_nxt  = 2'b11;
               end else begin
                  // A LINK already loaded the next pointer, so no stride then
                  if (!link_q) ptr_nxt = ptr_q + STRIDE;
                  state_nxt = FETCH;
               end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign desc_req   = desc_req_s;
   assign desc_ptr   = ptr_q;
   assign ram_addr   = addr_q;
   assign ram_rd     = ram_rd_s;
   assign ram_wr     = ram_wr_s;
   assign ram_wdata  = ram_wr_s ? fifo_rdata : '0;
   assign fifo_rd    = fifo_rd_s;
   assign fifo_wr    = fifo_wr_s;
   assign fifo_wdata = fifo_wr_s ? ram_rdata : '0;
   assign busy       = busy_s;
   assign done       = (state == DONE);
   assign error      = err_q;
   assign err_code   = code_q;

endmodule

// File: tb/tb_dma_adma_engine.sv
// Scoreboard bench for dma_adma_engine: expected strobes are queued by the stimulus
// and popped by a monitor running on the falling clock edge.
module tb_dma_adma_engine;

   localparam int K_DESC = 1, K_RRD = 2, K_FRD = 3, K_FWR = 4, K_RWR = 5, K_DONE = 6;

   typedef struct {
      int          k;
      logic [63:0] a;
      logic [7:0]  d;
   } ev_t;

   logic        clk_in = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0, continue_in = 1'b0, stop = 1'b0, write = 1'b0, error_in = 1'b0;
   logic [63:0] base_ptr = '0;
   logic        desc_req, desc_ack, desc_valid, desc_end;
   logic [63:0] desc_ptr, desc_addr, ram_addr;
   logic [1:0]  desc_act, err_code;
   logic [11:0] desc_len;
   logic        ram_rd, ram_wr, fifo_wr, fifo_rd, busy, done, error;
   logic [7:0]  ram_wdata, ram_rdata, fifo_wdata, fifo_rdata;
   logic        fifo_full = 1'b0, fifo_empty = 1'b0;
   logic        req_d = 1'b0;

   logic [63:0] t_ptr [4];
   logic        t_valid [4];
   logic        t_end [4];
   logic [1:0]  t_act [4];
   logic [63:0] t_addr [4];
   logic [11:0] t_len [4];
   int          t_n = 0;

   ev_t exp_q[$];
   int  ncheck = 0, npass = 0;
   int  st_seen = 0, fw_seen = 0, wr_seen = 0;

   dma_adma_engine dut (
      .clk_in(clk_in), .reset_n(reset_n), .start(start), .continue_in(continue_in),
      .stop(stop), .write(write), .error_in(error_in), .base_ptr(base_ptr),
      .desc_req(desc_req), .desc_ptr(desc_ptr), .desc_ack(desc_ack),
      .desc_valid(desc_valid), .desc_end(desc_end), .desc_act(desc_act),
      .desc_addr(desc_addr), .desc_len(desc_len),
      .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
      .fifo_full(fifo_full), .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata),
      .fifo_empty(fifo_empty), .busy(busy), .done(done), .error(error), .err_code(err_code)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [7:0] ram_pat(logic [63:0] a);
      return (a[7:0] * 8'd7) ^ 8'h5A;
   endfunction

   function automatic logic [7:0] fifo_pat(logic [63:0] a);
      return a[7:0] + 8'h61;
   endfunction

   // Memory-side models: read data one cycle after the strobe; ack on the 2nd request cycle
   always_ff @(posedge clk_in) begin
      if (ram_rd) ram_rdata <= ram_pat(ram_addr);
      if (fifo_rd) fifo_rdata <= fifo_pat(ram_addr);
      req_d <= desc_req && !desc_ack;
   end
   assign desc_ack = desc_req && req_d;

   always_comb begin
      desc_valid = 1'b0;
      desc_end   = 1'b0;
      desc_act   = 2'b00;
      desc_addr  = '0;
      desc_len   = '0;
      for (int i = 0; i < 4; i++) begin
         if (i < t_n && t_ptr[i] == desc_ptr) begin
            desc_valid = t_valid[i];
            desc_end   = t_end[i];
            desc_act   = t_act[i];
            desc_addr  = t_addr[i];
            desc_len   = t_len[i];
         end
      end
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      ncheck++;
      if (act === req) npass++;
      else $display("FAIL %s actual=%h required=%h", nm, act, req);
   endtask

   task automatic got(int k, logic [63:0] a, logic [7:0] d);
      ev_t e;
      st_seen++;
      if (exp_q.size() == 0) begin
         ncheck++;
         $display("FAIL unexpected_strobe actual kind=%0d a=%h d=%h required none", k, a, d);
      end else begin
         e = exp_q.pop_front();
         chk("ev_kind", 64'(k), 64'(e.k));
         chk("ev_addr", a, e.a);
         chk("ev_data", 64'(d), 64'(e.d));
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk_in);
         if (reset_n) begin
            if (desc_req && desc_ack) got(K_DESC, desc_ptr, 8'h00);
            if (ram_rd) got(K_RRD, ram_addr, 8'h00);
            if (fifo_rd) got(K_FRD, 64'h0, 8'h00);
            if (fifo_wr) begin got(K_FWR, 64'h0, fifo_wdata); fw_seen++; end
            if (ram_wr) begin got(K_RWR, ram_addr, ram_wdata); wr_seen++; end
            if (done) got(K_DONE, 64'h0, 8'h00);
         end
      end
   endtask

   task automatic push(int k, logic [63:0] a, logic [7:0] d);
      ev_t e;
      e.k = k; e.a = a; e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic push_words(logic wr, logic [63:0] a0, int n);
      for (int i = 0; i < n; i++) begin
         if (wr) begin
            push(K_RRD, a0 + 64'(i), 8'h00);
            push(K_FWR, 64'h0, ram_pat(a0 + 64'(i)));
         end else begin
            push(K_FRD, 64'h0, 8'h00);
            push(K_RWR, a0 + 64'(i), fifo_pat(a0 + 64'(i)));
         end
      end
   endtask

   task automatic set_desc(int i, logic [63:0] p, logic v, logic e, logic [1:0] act,
                           logic [63:0] a, logic [11:0] l);
      t_ptr[i] = p; t_valid[i] = v; t_end[i] = e; t_act[i] = act; t_addr[i] = a; t_len[i] = l;
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_idle(string nm);
      for (int i = 0; i < 400 && busy; i++) tick(1);
      chk({nm, "_timeout"}, 64'(busy), 64'h0);
      tick(2);
      chk({nm, "_queue_drained"}, 64'(exp_q.size()), 64'h0);
   endtask

   task automatic wait_fw(string nm, int target);
      for (int i = 0; i < 100 && fw_seen < target; i++) tick(1);
      chk({nm, "_wait_fifo_wr"}, 64'(fw_seen >= target), 64'h1);
   endtask

   initial begin
      int s0, f0;
      fork
         monitor();
      join_none

      // Reset state
      #2;
      chk("rst_busy", 64'(busy), 0);
      chk("rst_desc_req", 64'(desc_req), 0);
      chk("rst_desc_ptr", desc_ptr, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_err", {62'h0, error, done}, 0);
      chk("rst_err_code", 64'(err_code), 0);
      tick(2);
      reset_n = 1'b1;
      tick(1);

      // Single TRAN, RAM -> FIFO
      t_n = 1;
      set_desc(0, 64'h0, 1, 1, 2'b10, 64'h100, 12'd3);
      write = 1'b1;
      push(K_DESC, 64'h0, 0);
      push_words(1'b1, 64'h100, 3);
      push(K_DONE, 0, 0);
      do_start();
      write = 1'b0;
      wait_idle("tran_rd");
      chk("tran_rd_error", 64'(error), 0);

      // FIFO -> RAM with FIFO empty for 5 cycles
      fifo_empty = 1'b1;
      s0 = st_seen;
      f0 = wr_seen;
      push(K_DESC, 64'h0, 0);
      push_words(1'b0, 64'h100, 3);
      push(K_DONE, 0, 0);
      do_start();
      tick(5);
      chk("empty_no_ram_wr", 64'(wr_seen - f0), 0);
      chk("empty_only_fetch", 64'(st_seen - s0), 1);
      fifo_empty = 1'b0;
      wait_idle("tran_wr");
      chk("tran_wr_words", 64'(wr_seen - f0), 3);

      // NOP -> LINK -> TRAN chain
      t_n = 3;
      set_desc(0, 64'h0, 1, 0, 2'b00, 64'h0, 12'd0);
      set_desc(1, 64'h8, 1, 0, 2'b11, 64'h400, 12'd0);
      set_desc(2, 64'h400, 1, 1, 2'b10, 64'h200, 12'd2);
      write = 1'b1;
      push(K_DESC, 64'h0, 0);
      push(K_DESC, 64'h8, 0);
      push(K_DESC, 64'h400, 0);
      push_words(1'b1, 64'h200, 2);
      push(K_DONE, 0, 0);
      do_start();
      wait_idle("chain");

      // Stop / continue mid-transfer, len 4
      t_n = 1;
      set_desc(0, 64'h0, 1, 1, 2'b10, 64'h300, 12'd4);
      f0 = fw_seen;
      push(K_DESC, 64'h0, 0);
      push_words(1'b1, 64'h300, 4);
      push(K_DONE, 0, 0);
      do_start();
      wait_fw("stop", f0 + 2);
      stop = 1'b1;
      tick(2);
      s0 = st_seen;
      continue_in = 1'b1;
      tick(1);
      stop = 1'b0;
      continue_in = 1'b0;
      tick(4);
      chk("pause_no_strobe", 64'(st_seen - s0), 0);
      chk("pause_busy", 64'(busy), 1);
      chk("pause_words_done", 64'(fw_seen - f0), 2);
      continue_in = 1'b1;
      tick(1);
      continue_in = 1'b0;
      wait_idle("stop");
      chk("stop_total_words", 64'(fw_seen - f0), 4);

      // error_in during transfer
      f0 = fw_seen;
      push(K_DESC, 64'h0, 0);
      push_words(1'b1, 64'h300, 1);
      do_start();
      wait_fw("abort", f0 + 1);
      error_in = 1'b1;
      tick(1);
      error_in = 1'b0;
      s0 = st_seen;
      tick(5);
      chk("abort_error", 64'(error), 1);
      chk("abort_code", 64'(err_code), 2);
      chk("abort_busy", 64'(busy), 0);
      chk("abort_no_strobe", 64'(st_seen - s0), 0);

      // Invalid descriptor, started straight from ERR
      set_desc(0, 64'h0, 0, 1, 2'b10, 64'h300, 12'd4);
      push(K_DESC, 64'h0, 0);
      do_start();
      chk("restart_clears_error", 64'(error), 0);
      wait_idle("invalid");
      chk("invalid_code", {62'h0, error, err_code == 2'b01}, 3);

      // Self-referencing LINK hits the descriptor limit
      set_desc(0, 64'h0, 1, 0, 2'b11, 64'h0, 12'd0);
      for (int i = 0; i < 16; i++) push(K_DESC, 64'h0, 0);
      do_start();
      wait_idle("selflink");
      chk("selflink_code", {62'h0, error, err_code == 2'b11}, 3);

      // Asynchronous reset mid-transfer
      set_desc(0, 64'h0, 1, 1, 2'b10, 64'h180, 12'd4);
      f0 = fw_seen;
      push(K_DESC, 64'h0, 0);
      push_words(1'b1, 64'h180, 4);
      push(K_DONE, 0, 0);
      do_start();
      wait_fw("areset", f0 + 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("areset_strobes", {58'h0, desc_req, ram_rd, ram_wr, fifo_rd, fifo_wr, done}, 0);
      chk("areset_ptrs", desc_ptr | ram_addr, 0);
      chk("areset_data", {48'h0, ram_wdata, fifo_wdata}, 0);
      chk("areset_status", {60'h0, busy, error, err_code}, 0);
      exp_q.delete();
      tick(2);
      reset_n = 1'b1;
      s0 = st_seen;
      tick(6);
      chk("areset_no_strobe", 64'(st_seen - s0), 0);

      $display("%0d/%0d checks passed", npass, ncheck);
      $finish;
   end

endmodule
